// File: rtl/uart_link_pkg.sv
// -----------------------------------------------------------------------------
// uart_link_pkg
// Shared definitions for the switch-to-switch UART link (receiver and
// transmitter): default widths, payload field offsets and the receiver
// state encoding.
//
// Optional feature macro: UART_RX_PARITY_EN adds the PARITY state.
// -----------------------------------------------------------------------------
package uart_link_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_W       = 4;
  localparam int DEFAULT_ADDR_W       = 2;

  // Payload layout, LSB first on the wire: data, then destination, then origin.
  localparam int DATA_LSB = 0;
  localparam int DEST_LSB = DATA_LSB + DEFAULT_DATA_W;
  localparam int ORIG_LSB = DEST_LSB + DEFAULT_ADDR_W;

  // Field offsets for non-default widths.
  function automatic int dest_lsb(input int data_w);
    return DATA_LSB + data_w;
  endfunction

  function automatic int orig_lsb(input int data_w, input int addr_w);
    return DATA_LSB + data_w + addr_w;
  endfunction

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_packet_receiver_if.sv
// -----------------------------------------------------------------------------
// uart_packet_receiver_if
// Bundles the serial line, the board ID and the decoded-frame outputs of the
// UART packet receiver.
//   master : the receiver (consumes rx/local_id, drives the frame outputs)
//   slave  : the link controller / board side (drives rx/local_id)
// Signals:
//   rx, local_id                        - serial line and this board's ID
//   rx_data, rx_origin, rx_dest         - fields of the last good frame
//   display_data                        - data of the last matching frame
//   frame_valid, addr_match             - good-frame strobes
//   frame_error, parity_error           - error strobes
//   busy                                - receiver not in IDLE
// -----------------------------------------------------------------------------
interface uart_packet_receiver_if
  import uart_link_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              rx;
  logic [ADDR_W-1:0] local_id;
  logic [DATA_W-1:0] rx_data;
  logic [ADDR_W-1:0] rx_origin;
  logic [ADDR_W-1:0] rx_dest;
  logic [DATA_W-1:0] display_data;
  logic              frame_valid;
  logic              addr_match;
  logic              frame_error;
  logic              parity_error;
  logic              busy;

  modport master (
    input  rx, local_id,
    output rx_data, rx_origin, rx_dest, display_data,
           frame_valid, addr_match, frame_error, parity_error, busy
  );

  modport slave (
    output rx, local_id,
    input  rx_data, rx_origin, rx_dest, display_data,
           frame_valid, addr_match, frame_error, parity_error, busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge
// detector against a third registered copy.
// Ports:
//   clk, reset  - system clock, async active-high reset
//   rx          - raw serial line (idles high)
//   rx_line     - synchronised line
//   fall_edge   - high for one cycle after rx_line goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_line,
  output logic fall_edge
);

  logic rx_meta;
  logic rx_prev;

  // Reset to the idle level so leaving reset never looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_line <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_line <= rx_meta;
      rx_prev <= rx_line;
    end
  end

  assign fall_edge = rx_prev & ~rx_line;

endmodule

// File: rtl/uart_packet_receiver.sv
// -----------------------------------------------------------------------------
// uart_packet_receiver
// Receives one asynchronous frame (start, FRAME_W payload bits LSB first,
// optional even parity, stop), splits the payload into data / destination /
// origin, and latches matching data onto the display register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   - an even-parity bit follows the payload; a mismatch pulses
//               parity_error and discards the frame.
//   undefined - no parity bit; parity_error is constant 0.
//
// Ports:
//   clk    - system clock, all logic on posedge
//   reset  - asynchronous active-high reset
//   bus    - uart_packet_receiver_if.master (rx, local_id in; frame fields,
//            strobes and busy out)
// -----------------------------------------------------------------------------
module uart_packet_receiver
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_packet_receiver_if.master bus
);

  localparam int FRAME_W  = DATA_W + 2 * ADDR_W;
  localparam int BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int BIT_W    = $clog2(FRAME_W + 1);
  localparam int DEST_OFF = dest_lsb(DATA_W);
  localparam int ORIG_OFF = orig_lsb(DATA_W, ADDR_W);

  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(FRAME_W - 1);

  rx_state_t          state;
  rx_state_t          state_next;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [FRAME_W-1:0] payload;

  logic rx_line;
  logic fall_edge;

  logic baud_clr;
  logic bit_clr;
  logic shift_en;
  logic done_good;
  logic done_ferr;
  logic parity_bad;
  logic dest_hit;

`ifdef UART_RX_PARITY_EN
  logic parity_bit;
  logic par_load;
  logic done_perr;
  // Even parity: the parity bit equals the XOR of the payload bits.
  assign parity_bad = (parity_bit != ^payload);
`else
  assign parity_bad = 1'b0;
`endif

  uart_rx_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .rx        (bus.rx),
    .rx_line   (rx_line),
    .fall_edge (fall_edge)
  );

  wire tick_half = (baud_cnt == HALF_LAST);
  wire tick_full = (baud_cnt == FULL_LAST);

  assign dest_hit = (payload[DEST_OFF +: ADDR_W] == bus.local_id);
  assign bus.busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    baud_clr   = 1'b0;
    bit_clr    = 1'b0;
    shift_en   = 1'b0;
    done_good  = 1'b0;
    done_ferr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_load   = 1'b0;
    done_perr  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (fall_edge) begin
          state_next = START;
          baud_clr   = 1'b1;
          bit_clr    = 1'b1;
        end
      end
      START: begin
        // Mid-start-bit re-check rejects glitches shorter than half a bit.
        if (tick_half) begin
          baud_clr   = 1'b1;
          state_next = rx_line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          baud_clr = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          baud_clr   = 1'b1;
          par_load   = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          baud_clr   = 1'b1;
          state_next = IDLE;
          done_ferr  = ~rx_line;
          done_good  = rx_line & ~parity_bad;
`ifdef UART_RX_PARITY_EN
          done_perr  = parity_bad;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and payload shift register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      // NOTE: the payload is reset along with the control state even though
      // it is fully rewritten per frame, so no X ever reaches dest_hit.
      payload  <= '0;
    end else begin
      state <= state_next;
      if (baud_clr || state == IDLE) baud_cnt <= '0;
      else                           baud_cnt <= baud_cnt + 1'b1;
      if (bit_clr)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 1'b1;
      // LSB arrives first, so shifting in from the top leaves bit 0 at [0].
      if (shift_en) payload <= {rx_line, payload[FRAME_W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs: visible the cycle after the stop-bit sample
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.rx_data      <= '0;
      bus.rx_origin    <= '0;
      bus.rx_dest      <= '0;
      bus.display_data <= '0;
      bus.frame_valid  <= 1'b0;
      bus.addr_match   <= 1'b0;
      bus.frame_error  <= 1'b0;
    end else begin
      bus.frame_valid <= done_good;
      bus.addr_match  <= done_good & dest_hit;
      bus.frame_error <= done_ferr;
      if (done_good) begin
        bus.rx_data   <= payload[DATA_LSB +: DATA_W];
        bus.rx_dest   <= payload[DEST_OFF +: ADDR_W];
        bus.rx_origin <= payload[ORIG_OFF +: ADDR_W];
        // Non-matching frames leave the display untouched.
        if (dest_hit) bus.display_data <= payload[DATA_LSB +: DATA_W];
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_bit       <= 1'b0;
      bus.parity_error <= 1'b0;
    end else begin
      if (par_load) parity_bit <= rx_line;
      bus.parity_error <= done_perr;
    end
  end
`else
  assign bus.parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_packet_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_packet_receiver
// Self-checking bench for uart_packet_receiver (CLKS_PER_BIT=16, local_id=01).
// A table of frames with their expected results feeds a scoreboard queue; a
// monitor pops one entry per strobe cycle. Glitch rejection and reset in the
// middle of a frame are exercised by hand-written sequences.
// Honours UART_RX_PARITY_EN to add parity-bit frames.
// -----------------------------------------------------------------------------
module tb_uart_packet_receiver;
  import uart_link_pkg::*;

  localparam int CPB = 16;
  localparam int DW  = 4;
  localparam int AW  = 2;

  typedef struct packed {
    logic          fv;
    logic          am;
    logic          fe;
    logic          pe;
    logic [DW-1:0] data;
    logic [AW-1:0] orig;
    logic [AW-1:0] dest;
    logic [DW-1:0] disp;
  } exp_t;

  typedef struct {
    logic [7:0] payload;
    logic       stop;
    logic       par_bad;
    exp_t       exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_packet_receiver_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  uart_packet_receiver #(
    .CLKS_PER_BIT (CPB),
    .DATA_W       (DW),
    .ADDR_W       (AW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  exp_t last;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] p, input logic stop, input logic par_bad,
                              input logic fv, input logic am, input logic fe, input logic pe,
                              input logic [3:0] data, input logic [1:0] orig,
                              input logic [1:0] dest, input logic [3:0] disp);
    vec_t v;
    v.payload = p;
    v.stop    = stop;
    v.par_bad = par_bad;
    v.exp     = '{fv, am, fe, pe, data, orig, dest, disp};
    return v;
  endfunction

  // One scoreboard entry per cycle in which any strobe is high.
  always @(negedge clk) begin
    if (reset === 1'b0 &&
        (bus.frame_valid | bus.addr_match | bus.frame_error | bus.parity_error) !== 1'b0) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe",
              {bus.frame_valid, bus.addr_match, bus.frame_error, bus.parity_error}, 4'h0);
      end else begin
        mon_e = sb.pop_front();
        check("frame_valid",  bus.frame_valid,  mon_e.fv);
        check("addr_match",   bus.addr_match,   mon_e.am);
        check("frame_error",  bus.frame_error,  mon_e.fe);
        check("parity_error", bus.parity_error, mon_e.pe);
        check("rx_data",      bus.rx_data,      mon_e.data);
        check("rx_origin",    bus.rx_origin,    mon_e.orig);
        check("rx_dest",      bus.rx_dest,      mon_e.dest);
        check("display_data", bus.display_data, mon_e.disp);
      end
    end
  end

  task automatic send_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p, input logic stop, input logic par_bad);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(p[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^p) ^ par_bad);
`endif
    send_bit(stop);
    send_bit(1'b1);
  endtask

  task automatic run_vec(input vec_t v);
    sb.push_back(v.exp);
    send_frame(v.payload, v.stop, v.par_bad);
    check("frame_consumed", sb.size(), 0);
    last = v.exp;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int hi;
    logic [7:0] rp;
    vec_t post;

    // payload, stop, par_bad | fv am fe pe data orig dest disp
    vecs.push_back(mk(8'h9A, 1'b1, 1'b0, 1, 1, 0, 0, 4'hA, 2'b10, 2'b01, 4'hA));
    vecs.push_back(mk(8'h65, 1'b1, 1'b0, 1, 0, 0, 0, 4'h5, 2'b01, 2'b10, 4'hA));
    vecs.push_back(mk(8'h9A, 1'b0, 1'b0, 0, 0, 1, 0, 4'h5, 2'b01, 2'b10, 4'hA));
    vecs.push_back(mk(8'h51, 1'b1, 1'b0, 1, 1, 0, 0, 4'h1, 2'b01, 2'b01, 4'h1));
    vecs.push_back(mk(8'hC7, 1'b1, 1'b0, 1, 0, 0, 0, 4'h7, 2'b11, 2'b00, 4'h1));
    vecs.push_back(mk(8'h1F, 1'b1, 1'b0, 1, 1, 0, 0, 4'hF, 2'b00, 2'b01, 4'hF));
`ifdef UART_RX_PARITY_EN
    vecs.push_back(mk(8'h9A, 1'b1, 1'b1, 0, 0, 0, 1, 4'hF, 2'b00, 2'b01, 4'hF));
    vecs.push_back(mk(8'h9A, 1'b1, 1'b0, 1, 1, 0, 0, 4'hA, 2'b10, 2'b01, 4'hA));
    vecs.push_back(mk(8'h65, 1'b0, 1'b1, 0, 0, 1, 1, 4'hA, 2'b10, 2'b01, 4'hA));
`endif

    bus.rx       = 1'b1;
    bus.local_id = 2'b01;
    reset        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs",
          {bus.rx_data, bus.rx_origin, bus.rx_dest, bus.display_data,
           bus.frame_valid, bus.addr_match, bus.frame_error, bus.parity_error}, 0);
    check("rst_busy", bus.busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Short low pulse: START re-check must return to IDLE after 8 busy cycles.
    hi = 0;
    bus.rx = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (c == 3) bus.rx = 1'b1;
      if (bus.busy === 1'b1) hi++;
    end
    check("glitch_busy_len", hi, 8);
    check("glitch_busy_end", bus.busy, 1'b0);
    check("glitch_held",
          {bus.rx_data, bus.rx_origin, bus.rx_dest, bus.display_data},
          {last.data, last.orig, last.dest, last.disp});

    // Reset asserted in the middle of payload bit 4.
    rp = 8'h65;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(rp[i]);
    bus.rx = rp[4];
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_outputs",
          {bus.rx_data, bus.rx_origin, bus.rx_dest, bus.display_data,
           bus.frame_valid, bus.addr_match, bus.frame_error, bus.parity_error}, 0);
    check("midrst_busy", bus.busy, 1'b0);
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (CPB) @(negedge clk);
    check("post_rst_idle", bus.busy, 1'b0);

    post = mk(8'h9A, 1'b1, 1'b0, 1, 1, 0, 0, 4'hA, 2'b10, 2'b01, 4'hA);
    run_vec(post);

    repeat (CPB) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_packet_receiver.md
Name: uart_packet_receiver

Overview:
Parametrised serial receiver for the switch-to-switch UART link. It deserialises one asynchronous frame from `rx` and splits the payload into origin ID, destination ID and data fields. It then compares the destination against this board's `local_id`. Matched data is latched onto the display register; every good frame is also reported with a one-cycle strobe for the link controller.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be >= 4 and even.
- DATA_W, 4, width of the data field.
- ADDR_W, 2, width of each of the origin and destination ID fields.
- FRAME_W, DATA_W+2*ADDR_W (derived localparam), payload bits per frame.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- local_id  in  ADDR_W  this board's switch ID; static while frames arrive.
- rx_data  out  DATA_W  data field of the last good frame.
- rx_origin  out  ADDR_W  origin field of the last good frame.
- rx_dest  out  ADDR_W  destination field of the last good frame.
- display_data  out  DATA_W  data of the last good frame whose destination matched `local_id`.
- frame_valid  out  1  one-cycle pulse when a good frame completes.
- addr_match  out  1  one-cycle pulse, coincident with `frame_valid`, when `rx_dest == local_id`.
- frame_error  out  1  one-cycle pulse when the stop bit is sampled low.
- parity_error  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is not compiled in.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset:
  - All outputs go to 0; state goes to IDLE; counters go to 0.
  - The `rx` synchroniser flops reset to 1.
- Synchroniser and edge detect:
  - `rx` passes through a 2-flop synchroniser.
  - A falling edge of the synchronised `rx` is detected against a third registered copy.
- Frame format:
  - 1 start bit (0), then FRAME_W payload bits LSB first, then [parity], then 1 stop bit (1).
  - Payload packing: `[DATA_W-1:0]` = data; `[DATA_W +: ADDR_W]` = destination; `[DATA_W+ADDR_W +: ADDR_W]` = origin.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a falling edge, clear the bit counter and go to START. Otherwise stay.
  - START: wait CLKS_PER_BIT/2 cycles, then sample.
    - Sample 0: go to DATA.
    - Sample 1: glitch; go to IDLE with no output activity.
  - DATA: every CLKS_PER_BIT cycles, sample and shift the bit into `payload[bit_idx]`.
    - After FRAME_W bits, go to PARITY if compiled in, else STOP.
  - PARITY: wait CLKS_PER_BIT cycles, sample the parity bit, go to STOP.
  - STOP: wait CLKS_PER_BIT cycles, then sample.
    - Sample 1 with parity OK: update `rx_data`, `rx_origin` and `rx_dest`. Pulse `frame_valid`. If destinations match, also update `display_data` and pulse `addr_match`.
    - Sample 0: pulse `frame_error`; registered outputs do not change.
    - Either way, go to IDLE.
- Output update: the strobes and register updates take effect in the cycle after the stop-bit sample.
- Non-matching good frame: `display_data` holds its previous value and is not cleared.
- Line held low after a frame error: no new frame starts until a fresh falling edge is seen.
- Reset mid-frame: the frame is aborted, outputs are cleared, and reception restarts from IDLE.
- Counter widths: `$clog2(CLKS_PER_BIT)` for the baud counter; `$clog2(FRAME_W+1)` for the bit counter. The baud counter wraps to 0 at each sample.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The PARITY state is included; one even-parity bit follows the payload.
  - A mismatch pulses `parity_error` and discards the frame: no `frame_valid`, no register update.
  - A frame with both a parity mismatch and a bad stop bit pulses both `parity_error` and `frame_error`.
- Undefined: the PARITY state is absent; `parity_error` is constant 0; the frame length is 10 bits for the defaults.

Decomposition:
- Package `uart_link_pkg`:
  - state enum `rx_state_t`.
  - localparams for the field offsets (`DATA_LSB`, `DEST_LSB`, `ORIG_LSB`).
  - the default widths shared with the transmitter.
- One sub-module, `uart_rx_sync`: the 2-flop synchroniser plus falling-edge detector.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and `local_id`=2'b01; timing is measured from the stop-bit sample.
- Send 0x9A: one cycle later, `frame_valid`=1, `addr_match`=1, `rx_data`=4'hA, `rx_dest`=2'b01, `rx_origin`=2'b10, `display_data`=4'hA.
- Then send 0x65: `frame_valid`=1, `addr_match`=0, `rx_data`=4'h5, `rx_dest`=2'b10, `display_data` stays 4'hA.
- Drive `rx` low for 4 cycles, then high: `busy` drops after 8 cycles; no strobes; outputs unchanged.
- Send 0x9A with the stop bit = 0: `frame_error` pulses once; `frame_valid`=0; `rx_data` unchanged. A following good 0x51 is received correctly (`display_data`=4'h1).
- Assert `reset` during bit 4 of a frame: all outputs are 0 and `busy`=0 immediately. The next full frame 0x9A is received correctly.
- With UART_RX_PARITY_EN, send 0x9A with the parity bit = 1 (wrong): `parity_error` pulses; no `frame_valid`. With parity = 0, the frame is accepted as in the first scenario.
